ps2_scan_ctrl: RTL and testbench
================================

Name: ps2_scan_ctrl

Overview:
- Sequencer between the PS/2 keyboard receiver FIFO and the CPU/game logic.
- Pops raw scan-code bytes from the receiver with a single-cycle active-low read strobe.
- Parses set-2 prefixes (E0 extended, F0 break, E1 pause) and pushes complete key events into a small event queue for the CPU.
- Maintains a live pressed-key bitmap for the game's control keys.

Parameters:
- EVQ_DEPTH, 4, event queue depth in entries; must be a power of two, at least 2.
- FILTER_REPEAT, 1, when 1, typematic make events for a tracked key whose bitmap bit is already set are not queued.

Ports:
- clk  in  1  system clock (50 MHz)
- clrn  in  1  synchronous active-low reset
- kb_ready  in  1  receiver FIFO not empty
- kb_data  in  8  receiver FIFO head byte (combinational from receiver)
- kb_overflow  in  1  receiver FIFO overflow flag
- kb_rdn  out  1  read strobe to receiver, active low, registered
- ev_valid  out  1  event queue not empty
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event had E0 prefix
- ev_break  out  1  head event is a release (F0 prefix)
- ev_ack  in  1  CPU pops head event; ignored when ev_valid=0
- key_state  out  8  pressed bitmap: [0] up E0 75, [1] down E0 72, [2] left E0 6B, [3] right E0 74, [4] space 29, [5] enter 5A, [6] esc 76, [7] P 4D
- ev_overflow  out  1  sticky: an event was dropped because the queue was full
- kb_lost  out  1  sticky: kb_overflow was seen high
- clr_status  in  1  one-cycle pulse clears ev_overflow and kb_lost

Behaviour:
- Reset (clrn=0 at posedge):
  - FSM goes to IDLE; kb_rdn=1.
  - Queue empty, so ev_valid=0; ev_code, ev_ext and ev_break read 0.
  - key_state=0, ev_overflow=0, kb_lost=0; prefix flags ext, brk and skip counter cleared.
  - Reset mid-parse discards the partial sequence.
- FSM states: IDLE, POP, PARSE.
  - IDLE: if kb_ready=1, latch kb_data into byte_r, drive kb_rdn<=0, go to POP. Otherwise stay.
  - POP: kb_rdn is low for exactly this cycle; the receiver advances at the end of it. Set kb_rdn<=1, go to PARSE.
  - PARSE: classify byte_r and return to IDLE. Never more than one pop per 3 cycles.
- Parse rules, first match wins:
  - skip>0: decrement skip, discard the byte.
  - E1: set skip=7 (pause sequence, 8 bytes total), clear ext and brk, no event.
  - F0: set brk=1.
  - E0: set ext=1.
  - AA, FA, EE, FE, 00, FF: discard and clear ext and brk.
  - Any other byte: form event {ext, brk, byte_r}, then clear ext and brk.
- Bitmap update for a formed event:
  - A tracked key matches only when both code and ext match.
  - Make sets the bit; break clears it.
  - Suppression: make, bit already set, and FILTER_REPEAT=1 → bitmap unchanged, no push.
- Event push:
  - Accepted when count<EVQ_DEPTH, or when the queue is full and an ev_ack pop occurs in the same cycle.
  - Otherwise the event is dropped and ev_overflow<=1. The bitmap is still updated.
- Pop: ev_valid & ev_ack at a posedge advances the read pointer. A simultaneous push and pop leaves count unchanged. Pointers wrap modulo EVQ_DEPTH.
- Latency: byte at head with kb_ready=1 in cycle t → kb_rdn low in t+1 → ev_valid high (if the queue was empty) in t+3.
- Status flags:
  - kb_lost<=1 any cycle kb_overflow=1.
  - clr_status clears both sticky flags. A set event in the same cycle wins over clr_status.
- Outputs ev_code, ev_ext and ev_break always reflect the queue head and hold stable until ack.

Test Plan:
- Byte 1D at kb_ready, queue empty → kb_rdn low exactly 1 cycle (t+1); ev_valid=1 at t+3 with ev_code=1D, ev_ext=0, ev_break=0; key_state=00.
- Sequence E0 75, then E0 F0 75 → two events {1,0,75} and {1,1,75}; key_state[0] goes 1 then 0; no events for the prefixes.
- 29, 29, 29 with FILTER_REPEAT=1 → one event only; key_state[4]=1. Same stimulus with FILTER_REPEAT=0 → three events.
- E1 14 77 E1 F0 14 F0 77, then 5A → only event {0,0,5A}; key_state[5]=1.
- Queue filled to EVQ_DEPTH with no ack, then one more make → event dropped and ev_overflow=1. Repeat with ev_ack in the push cycle → accepted, no overflow. clr_status → flag clears.
- clrn=0 after E0 F0 received, then 75 → event {0,0,75}, key_state=00; kb_overflow pulse → kb_lost=1 until clr_status.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl
// Sits between the PS/2 receiver FIFO and the CPU. It pops set-2 scan-code
// bytes one at a time, folds the E0/F0/E1 prefixes into complete key events,
// queues those events for the CPU, and keeps a live pressed bitmap for the
// eight game control keys.
//
// Ports:
//   clk          system clock
//   clrn         synchronous active-low reset
//   kb_ready     receiver FIFO not empty
//   kb_data      receiver FIFO head byte
//   kb_overflow  receiver FIFO overflow flag
//   kb_rdn       registered active-low read strobe to the receiver
//   ev_valid     event queue not empty
//   ev_code      head event scan code (0 when queue empty)
//   ev_ext       head event had an E0 prefix
//   ev_break     head event is a key release
//   ev_ack       CPU pops the head event
//   key_state    pressed bitmap: up, down, left, right, space, enter, esc, P
//   ev_overflow  sticky: an event was dropped on a full queue
//   kb_lost      sticky: receiver overflow was seen
//   clr_status   pulse clearing both sticky flags
module ps2_scan_ctrl #(
    parameter int EVQ_DEPTH     = 4,
    parameter int FILTER_REPEAT = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       kb_rdn,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_ack,
    output logic [7:0] key_state,
    output logic       ev_overflow,
    output logic       kb_lost,
    input  logic       clr_status
);

    localparam int AW = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(EVQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        PARSE = 2'd2
    } state_t;

    state_t        state_r;
    logic [7:0]    byte_r;
    logic          ext_r;
    logic          brk_r;
    logic [2:0]    skip_r;
    logic          kb_rdn_r;
    logic [9:0]    evq_r [EVQ_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    key_state_r;
    logic          ev_overflow_r;
    logic          kb_lost_r;

    logic          ev_form_s;
    logic          key_hit_s;
    logic [2:0]    key_idx_s;
    logic          suppress_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [3:0]    key_lookup_s;
    logic [9:0]    head_s;

    // Tracked-key lookup on {ext, code}; returns {hit, bitmap index}.
    function automatic logic [3:0] key_index(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h175:  key_index = 4'b1000;
            9'h172:  key_index = 4'b1001;
            9'h16B:  key_index = 4'b1010;
            9'h174:  key_index = 4'b1011;
            9'h029:  key_index = 4'b1100;
            9'h05A:  key_index = 4'b1101;
            9'h076:  key_index = 4'b1110;
            9'h04D:  key_index = 4'b1111;
            default: key_index = 4'b0000;
        endcase
    endfunction

    // Protocol replies and error codes that carry no key information.
    function automatic logic is_noise(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_noise = 1'b1;
            default:                                  is_noise = 1'b0;
        endcase
    endfunction

    // Classify the byte being parsed and decide push / drop / pop for this cycle.
    always_comb begin
        ev_form_s    = 1'b0;
        suppress_s   = 1'b0;
        push_ok_s    = 1'b0;
        drop_s       = 1'b0;
        key_lookup_s = key_index(ext_r, byte_r);
        key_hit_s    = key_lookup_s[3];
        key_idx_s    = key_lookup_s[2:0];
        pop_s        = (count_r != {CW{1'b0}}) && ev_ack;
        if ((state_r == PARSE) && (skip_r == 3'd0) && (byte_r != 8'hE1) &&
            (byte_r != 8'hF0) && (byte_r != 8'hE0) && !is_noise(byte_r)) begin
            ev_form_s = 1'b1;
        end else begin
            ev_form_s = 1'b0;
        end
        // Typematic repeat of a key already held down is swallowed entirely.
        if (ev_form_s && key_hit_s && !brk_r && key_state_r[key_idx_s] &&
            (FILTER_REPEAT != 0)) begin
            suppress_s = 1'b1;
        end else begin
            suppress_s = 1'b0;
        end
        // A full queue still accepts when the head leaves on the same edge.
        if (ev_form_s && !suppress_s) begin
            push_ok_s = (count_r < DEPTH_C) || pop_s;
            drop_s    = !push_ok_s;
        end else begin
            push_ok_s = 1'b0;
            drop_s    = 1'b0;
        end
    end

    // Sequencer, prefix state, event queue, bitmap and sticky status.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r       <= IDLE;
            byte_r        <= 8'h00;
            ext_r         <= 1'b0;
            brk_r         <= 1'b0;
            skip_r        <= 3'd0;
            kb_rdn_r      <= 1'b1;
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            key_state_r   <= 8'h00;
            ev_overflow_r <= 1'b0;
            kb_lost_r     <= 1'b0;
            for (int i = 0; i < EVQ_DEPTH; i++) begin
                evq_r[i] <= 10'h000;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (kb_ready) begin
                        byte_r   <= kb_data;
                        kb_rdn_r <= 1'b0;
                        state_r  <= POP;
                    end else begin
                        kb_rdn_r <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                POP: begin
                    kb_rdn_r <= 1'b1;
                    state_r  <= PARSE;
                end
                PARSE: begin
                    state_r <= IDLE;
                    if (skip_r != 3'd0) begin
                        skip_r <= skip_r - 3'd1;
                    end else if (byte_r == 8'hE1) begin
                        // Pause is E1 followed by seven fixed bytes.
                        skip_r <= 3'd7;
                        ext_r  <= 1'b0;
                        brk_r  <= 1'b0;
                    end else if (byte_r == 8'hF0) begin
                        brk_r <= 1'b1;
                    end else if (byte_r == 8'hE0) begin
                        ext_r <= 1'b1;
                    end else begin
                        ext_r <= 1'b0;
                        brk_r <= 1'b0;
                    end
                end
                default: begin
                    kb_rdn_r <= 1'b1;
                    state_r  <= IDLE;
                end
            endcase

            if (push_ok_s) begin
                evq_r[wr_ptr_r] <= {ext_r, brk_r, byte_r};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase

            // The bitmap follows every formed event, even one the queue drops.
            if (ev_form_s && key_hit_s && !suppress_s) begin
                key_state_r[key_idx_s] <= !brk_r;
            end

            if (drop_s) begin
                ev_overflow_r <= 1'b1;
            end else if (clr_status) begin
                ev_overflow_r <= 1'b0;
            end
            if (kb_overflow) begin
                kb_lost_r <= 1'b1;
            end else if (clr_status) begin
                kb_lost_r <= 1'b0;
            end
        end
    end

    assign head_s      = evq_r[rd_ptr_r];
    assign kb_rdn      = kb_rdn_r;
    assign ev_valid    = (count_r != {CW{1'b0}});
    assign ev_code     = ev_valid ? head_s[7:0] : 8'h00;
    assign ev_break    = ev_valid ? head_s[8]   : 1'b0;
    assign ev_ext      = ev_valid ? head_s[9]   : 1'b0;
    assign key_state   = key_state_r;
    assign ev_overflow = ev_overflow_r;
    assign kb_lost     = kb_lost_r;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: a receiver-FIFO model feeds bytes, a queue-based
// reference model predicts every output each cycle, a vector table and
// hand sequences pin the documented corner cases. A second instance with
// repeat filtering disabled counts raw events.
module tb_ps2_scan_ctrl;

    localparam int D = 4;
    localparam int FILT_A = 1;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;
    logic       ev_ack = 1'b0;
    logic       clr_status = 1'b0;
    logic       ack_b = 1'b1;
    logic       kb_rdn, ev_valid, ev_ext, ev_break, ev_overflow, kb_lost;
    logic [7:0] ev_code, key_state;
    logic       b_rdn, b_valid, b_ext, b_break, b_ovf, b_lost;
    logic [7:0] b_code, b_keys;

    int checks = 0;
    int errors = 0;
    int b_cnt = 0;

    // receiver and reference model state
    logic [7:0] rx_q[$];
    logic [9:0] mq[$];
    logic [7:0] mkeys = 8'h00;
    logic       movf = 1'b0, mlost = 1'b0, mext = 1'b0, mbrk = 1'b0;
    int         mskip = 0;
    int         gap = 100;
    logic       p1v = 1'b0, p2v = 1'b0;
    logic [7:0] p1b = 8'h00, p2b = 8'h00;
    logic [8:0] trk [8];

    ps2_scan_ctrl #(.EVQ_DEPTH(D), .FILTER_REPEAT(FILT_A)) dut (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_rdn(kb_rdn), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_ack(ev_ack),
        .key_state(key_state), .ev_overflow(ev_overflow), .kb_lost(kb_lost),
        .clr_status(clr_status));

    ps2_scan_ctrl #(.EVQ_DEPTH(D), .FILTER_REPEAT(0)) dut_b (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_rdn(b_rdn), .ev_valid(b_valid),
        .ev_code(b_code), .ev_ext(b_ext), .ev_break(b_break), .ev_ack(ack_b),
        .key_state(b_keys), .ev_overflow(b_ovf), .kb_lost(b_lost),
        .clr_status(clr_status));

    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int trk_idx(input logic e, input logic [7:0] b);
        trk_idx = -1;
        for (int i = 0; i < 8; i++) if (trk[i] == {e, b}) trk_idx = i;
    endfunction

    // One byte through the set-2 rules at the event level.
    task automatic model_parse(input logic [7:0] b, input int sz, input logic popped,
                               output logic dropped);
        int idx;
        dropped = 1'b0;
        if (mskip > 0) mskip--;
        else if (b == 8'hE1) begin mskip = 7; mext = 1'b0; mbrk = 1'b0; end
        else if (b == 8'hF0) mbrk = 1'b1;
        else if (b == 8'hE0) mext = 1'b1;
        else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            mext = 1'b0; mbrk = 1'b0;
        end else begin
            idx = trk_idx(mext, b);
            if (!(idx >= 0 && !mbrk && mkeys[idx] && FILT_A != 0)) begin
                if (idx >= 0) mkeys[idx] = !mbrk;
                if (sz < D || popped) mq.push_back({mext, mbrk, b});
                else begin dropped = 1'b1; movf = 1'b1; end
            end
            mext = 1'b0; mbrk = 1'b0;
        end
    endtask

    // Advance one clock: update the model for the edge, move the receiver, compare.
    task automatic cycle();
        logic ack_c, clr_c, ovf_c, rst_c, rdy_c, popped, dropped, exp_low;
        logic [9:0] h;
        int sz;
        ack_c = ev_ack; clr_c = clr_status; ovf_c = kb_overflow;
        rst_c = clrn; rdy_c = kb_ready; exp_low = 1'b0;
        @(posedge clk); #1;
        if (!rst_c) begin
            mq.delete(); mkeys = 8'h00; movf = 1'b0; mlost = 1'b0;
            mext = 1'b0; mbrk = 1'b0; mskip = 0; p1v = 1'b0; p2v = 1'b0; gap = 100;
        end else begin
            sz = mq.size();
            popped = (sz > 0) && ack_c;
            if (popped) void'(mq.pop_front());
            dropped = 1'b0;
            if (p2v) model_parse(p2b, sz, popped, dropped);
            if (!dropped && clr_c) movf = 1'b0;
            if (ovf_c) mlost = 1'b1; else if (clr_c) mlost = 1'b0;
            p2v = p1v; p2b = p1b; p1v = 1'b0;
            if (gap < 100) gap++;
            // a read happens one cycle after the receiver shows data to an idle sequencer
            if (rdy_c && gap >= 3) begin
                exp_low = 1'b1; gap = 0; p1v = 1'b1; p1b = rx_q.pop_front();
            end
        end
        kb_ready = (rx_q.size() != 0);
        kb_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        h = (mq.size() != 0) ? mq[0] : 10'h000;
        check("kb_rdn", kb_rdn, !exp_low);
        check("ev_valid", ev_valid, mq.size() != 0);
        check("ev_code", ev_code, h[7:0]);
        check("ev_ext", ev_ext, h[9]);
        check("ev_break", ev_break, h[8]);
        check("key_state", key_state, mkeys);
        check("ev_overflow", ev_overflow, movf);
        check("kb_lost", kb_lost, mlost);
        if (b_valid) b_cnt++;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        kb_ready = 1'b1;
        kb_data  = rx_q[0];
    endtask

    task automatic drain_rx();
        int n = 0;
        while (rx_q.size() != 0 && n < 400) begin cycle(); n++; end
        check("rx_drain", rx_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic ack_all();
        int n = 0;
        ev_ack = 1'b1;
        while (mq.size() != 0 && n < 50) begin cycle(); n++; end
        ev_ack = 1'b0;
        check("ack_drain", mq.size(), 0);
        cycle();
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic        v;
        logic        x;
        logic        k;
        logic [7:0]  c;
        logic [7:0]  keys;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] rb;
        int r;
        trk = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h05A, 9'h076, 9'h04D};
        tbl[0]  = '{24'h1D0000, 1, 1'b1, 1'b0, 1'b0, 8'h1D, 8'h00};
        tbl[1]  = '{24'hE07500, 2, 1'b1, 1'b1, 1'b0, 8'h75, 8'h01};
        tbl[2]  = '{24'hE0F075, 3, 1'b1, 1'b1, 1'b1, 8'h75, 8'h00};
        tbl[3]  = '{24'h750000, 1, 1'b1, 1'b0, 1'b0, 8'h75, 8'h00};
        tbl[4]  = '{24'hE06B00, 2, 1'b1, 1'b1, 1'b0, 8'h6B, 8'h04};
        tbl[5]  = '{24'h290000, 1, 1'b1, 1'b0, 1'b0, 8'h29, 8'h14};
        tbl[6]  = '{24'h290000, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h14};
        tbl[7]  = '{24'hF02900, 2, 1'b1, 1'b0, 1'b1, 8'h29, 8'h04};
        tbl[8]  = '{24'hAA0000, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04};
        tbl[9]  = '{24'hE0AA72, 3, 1'b1, 1'b0, 1'b0, 8'h72, 8'h04};
        tbl[10] = '{24'hE0F06B, 3, 1'b1, 1'b1, 1'b1, 8'h6B, 8'h00};
        tbl[11] = '{24'hF05A00, 2, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00};

        // reset state
        clrn = 1'b0;
        repeat (2) cycle();
        clrn = 1'b1;
        cycle();
        check("rst_rdn", kb_rdn, 1'b1);
        check("rst_valid", ev_valid, 1'b0);
        check("rst_keys", key_state, 8'h00);

        // vector table: bytes in, head event and bitmap out
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < tbl[i].n; j++) feed(tbl[i].bytes[23 - 8*j -: 8]);
            drain_rx();
            check($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].v);
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_code", i), ev_code, tbl[i].c);
                check($sformatf("tbl%0d_ext", i), ev_ext, tbl[i].x);
                check($sformatf("tbl%0d_brk", i), ev_break, tbl[i].k);
            end
            check($sformatf("tbl%0d_keys", i), key_state, tbl[i].keys);
            ack_all();
        end

        // latency of a single byte into an empty queue
        feed(8'h1D);
        cycle(); check("lat_rdn_low", kb_rdn, 1'b0);
        cycle(); check("lat_rdn_high", kb_rdn, 1'b1); check("lat_not_yet", ev_valid, 1'b0);
        cycle(); check("lat_valid", ev_valid, 1'b1); check("lat_code", ev_code, 8'h1D);
        check("lat_keys", key_state, 8'h00);
        ack_all();

        // pause sequence is swallowed whole
        foreach (trk[i]) begin end
        feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
        feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77); feed(8'h5A);
        drain_rx();
        check("pause_code", ev_code, 8'h5A);
        check("pause_ext_brk", {ev_ext, ev_break}, 2'b00);
        check("pause_keys5", key_state[5], 1'b1);
        ev_ack = 1'b1; cycle(); ev_ack = 1'b0;
        check("pause_single", ev_valid, 1'b0);

        // typematic repeat: filtered on dut, all three on dut_b
        b_cnt = 0;
        feed(8'h29); feed(8'h29); feed(8'h29);
        drain_rx();
        check("rep_keys4", key_state[4], 1'b1);
        ev_ack = 1'b1; cycle(); ev_ack = 1'b0;
        check("rep_single", ev_valid, 1'b0);
        check("rep_nofilter_cnt", b_cnt, 3);
        feed(8'hF0); feed(8'h29); drain_rx(); ack_all();

        // full queue: drop, clear, then accept with ack in the push cycle
        feed(8'h1C); feed(8'h1B); feed(8'h23); feed(8'h2B); feed(8'h34);
        drain_rx();
        check("ovf_set", ev_overflow, 1'b1);
        check("ovf_head", ev_code, 8'h1C);
        clr_status = 1'b1; cycle(); clr_status = 1'b0;
        check("ovf_clr", ev_overflow, 1'b0);
        feed(8'h3B);
        cycle(); cycle();
        ev_ack = 1'b1; cycle(); ev_ack = 1'b0;
        check("ovf_accept", ev_overflow, 1'b0);
        check("ovf_head2", ev_code, 8'h1B);
        ack_all();

        // reset mid-sequence discards the pending prefixes
        feed(8'hE0); feed(8'hF0); drain_rx();
        clrn = 1'b0; cycle(); clrn = 1'b1;
        check("mid_rst_keys", key_state, 8'h00);
        feed(8'h75); drain_rx();
        check("mid_rst_code", ev_code, 8'h75);
        check("mid_rst_ext_brk", {ev_ext, ev_break}, 2'b00);
        check("mid_rst_keys2", key_state, 8'h00);
        ack_all();
        kb_overflow = 1'b1; cycle(); kb_overflow = 1'b0; cycle();
        check("lost_set", kb_lost, 1'b1);
        kb_overflow = 1'b1; clr_status = 1'b1; cycle(); kb_overflow = 1'b0;
        check("lost_set_wins", kb_lost, 1'b1);
        cycle(); clr_status = 1'b0;
        check("lost_clr", kb_lost, 1'b0);

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if (rx_q.size() < 3 && $urandom_range(3) == 0) begin
                r = $urandom_range(15);
                case (r)
                    0: rb = 8'h75; 1: rb = 8'h72; 2: rb = 8'h6B; 3: rb = 8'h74;
                    4: rb = 8'h29; 5: rb = 8'h5A; 6: rb = 8'h76; 7: rb = 8'h4D;
                    8, 9: rb = 8'hE0;
                    10, 11: rb = 8'hF0;
                    12: rb = ($urandom_range(3) == 0) ? 8'hE1 : 8'h1C;
                    13: rb = 8'hAA;
                    default: rb = 8'($urandom);
                endcase
                feed(rb);
            end
            ev_ack      = ($urandom_range(2) == 0);
            clr_status  = ($urandom_range(39) == 0);
            kb_overflow = ($urandom_range(59) == 0);
            clrn        = ($urandom_range(499) != 0);
            cycle();
        end
        ev_ack = 1'b0; clr_status = 1'b0; kb_overflow = 1'b0; clrn = 1'b1;
        drain_rx();
        ack_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
